// File: rtl/nios_sqrt_ctrl.sv
// Avalon-MM sequencer for the external square-root coprocessor.
// Optional interrupt output: define NIOS_SQRT_CTRL_IRQ_EN.
module nios_sqrt_ctrl #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic [31:0] core_operand,
    output logic        core_start,
    output logic        core_abort,
    input  logic [31:0] core_result,
    input  logic        core_done
`ifdef NIOS_SQRT_CTRL_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q;
    state_t            state_d;
    logic [CNT_W-1:0]  wdog_q;
    logic [31:0]       operand_q;
    logic [31:0]       result_q;
    logic              done_q;
    logic              timeout_q;
    logic              ie_q;
    logic [31:0]       rd_mux;

    logic wr;
    logic wr_op;
    logic wr_ctl;
    logic wr_sts;
    logic start_req;
    logic start_acc;
    logic done_set;
    logic to_set;
    logic wd_clr;
    logic wd_inc;

    assign wr        = chipselect & ~write_n;
    assign wr_op     = wr & (address == 2'd0);
    assign wr_ctl    = wr & (address == 2'd1);
    assign wr_sts    = wr & (address == 2'd2);
    assign start_req = wr_ctl & writedata[0];

    // Next-state and core handshake outputs of the job sequencer
    always_comb begin
        state_d    = state_q;
        core_start = 1'b0;
        core_abort = 1'b0;
        start_acc  = 1'b0;
        done_set   = 1'b0;
        to_set     = 1'b0;
        wd_clr     = 1'b0;
        wd_inc     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_req) begin
                    start_acc = 1'b1;
                    state_d   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                core_start = 1'b1;
                wd_clr     = 1'b1;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    done_set = 1'b1;
                    state_d  = S_IDLE;
                end else if (wdog_q == WD_LIMIT) begin
                    core_abort = 1'b1;
                    to_set     = 1'b1;
                    state_d    = S_IDLE;
                end else begin
                    wd_inc = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Watchdog counter, cleared on launch and advanced while waiting
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)    wdog_q <= '0;
        else if (wd_clr) wdog_q <= '0;
        else if (wd_inc) wdog_q <= wdog_q + CNT_W'(1);
    end

    // Operand register and the copy held for the job in flight
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            operand_q    <= '0;
            core_operand <= '0;
        end else begin
            if (wr_op)     operand_q    <= writedata;
            if (start_acc) core_operand <= operand_q;
        end
    end

    // Result capture only on successful completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      result_q <= '0;
        else if (done_set) result_q <= core_result;
    end

    // Sticky status bits: set beats W1C, start clears both
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            if (done_set)                     done_q <= 1'b1;
            else if (start_acc)               done_q <= 1'b0;
            else if (wr_sts && writedata[1])  done_q <= 1'b0;
            if (to_set)                       timeout_q <= 1'b1;
            else if (start_acc)               timeout_q <= 1'b0;
            else if (wr_sts && writedata[2])  timeout_q <= 1'b0;
        end
    end

`ifdef NIOS_SQRT_CTRL_IRQ_EN
    // Interrupt enable bit and registered interrupt line
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ie_q <= 1'b0;
            irq  <= 1'b0;
        end else begin
            if (wr_ctl) ie_q <= writedata[1];
            irq <= ie_q & (done_q | timeout_q);
        end
    end
`else
    assign ie_q = 1'b0;
`endif

    // Register map read decode
    always_comb begin
        rd_mux = '0;
        case (address)
            2'd0: rd_mux = operand_q;
            2'd1: rd_mux = {30'b0, ie_q, 1'b0};
            2'd2: rd_mux = {29'b0, timeout_q, done_q, state_q != S_IDLE};
            2'd3: rd_mux = result_q;
            default: rd_mux = '0;
        endcase
    end

    // Read data with fixed one-cycle latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) readdata <= '0;
        else          readdata <= rd_mux;
    end

endmodule

// File: tb/tb_nios_sqrt_ctrl.sv
// Scoreboard bench for nios_sqrt_ctrl: register reads checked by a
// monitor against a queue filled from a behavioural model.
module tb_nios_sqrt_ctrl;

    localparam int T = 64;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [31:0] core_operand;
    logic        core_start;
    logic        core_abort;
    logic [31:0] core_result;
    logic        core_done;
`ifdef NIOS_SQRT_CTRL_IRQ_EN
    logic        irq;
`endif

    nios_sqrt_ctrl #(.TIMEOUT_CYCLES(T), .CNT_W(16)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .core_operand (core_operand),
        .core_start   (core_start),
        .core_abort   (core_abort),
        .core_result  (core_result),
        .core_done    (core_done)
`ifdef NIOS_SQRT_CTRL_IRQ_EN
        ,
        .irq          (irq)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", n, got, exp);
        end
    endtask

    function automatic logic [31:0] isqrt(input logic [31:0] x);
        longint lo = 0;
        longint hi = 65536;
        longint mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= longint'(x)) lo = mid;
            else hi = mid;
        end
        return lo[31:0];
    endfunction

    // Behavioural model of the register file and job outcome
    logic [31:0] m_op, m_res, job_op;
    logic        m_done, m_to, m_busy, m_ie;
    int          job_delay;
    int          exp_start = 0;
    int          exp_abort = 0;

    // Core model and core-side observation
    int          rsp_delay = -1;
    logic        rsp_pend = 1'b0;
    int          rsp_cyc = 0;
    logic [31:0] rsp_val = '0;
    int          n_start = 0;
    int          n_abort = 0;
    int          start_cyc = 0;
    int          abort_cyc = 0;
    logic [31:0] start_op = '0;

    typedef struct packed {
        logic [1:0]  a;
        logic [31:0] v;
    } rd_t;
    rd_t rdq[$];

    logic rd_vld;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) rd_vld <= 1'b0;
        else          rd_vld <= chipselect & write_n;
    end

    // Read monitor: pops the expected value for each completed read
    initial begin
        rd_t e;
        forever begin
            @(negedge clk);
            if (rd_vld === 1'b1) begin
                if (rdq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rd_unexpected got=%0h want=none", readdata);
                end else begin
                    e = rdq.pop_front();
                    chk($sformatf("rd_addr%0d", e.a), readdata, e.v);
                end
            end
        end
    end

    // Core-side monitor: counts launches/aborts, schedules responses
    initial begin
        forever begin
            @(negedge clk);
            if (core_start === 1'b1) begin
                n_start++;
                start_cyc = cyc;
                start_op  = core_operand;
                if (rsp_delay > 0) begin
                    rsp_pend = 1'b1;
                    rsp_cyc  = cyc + rsp_delay;
                    rsp_val  = isqrt(core_operand);
                end else begin
                    rsp_pend = 1'b0;
                end
            end
            if (core_abort === 1'b1) begin
                n_abort++;
                abort_cyc = cyc;
            end
        end
    end

    // Core driver: one-cycle done pulse, garbage result otherwise
    initial begin
        core_done   = 1'b0;
        core_result = '0;
        forever begin
            @(posedge clk);
            #1;
            core_done   = 1'b0;
            core_result = $urandom;
            if (rsp_pend && cyc == rsp_cyc) begin
                core_done   = 1'b1;
                core_result = rsp_val;
                rsp_pend    = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        case (a)
            2'd0: m_op = d;
            2'd1: begin
`ifdef NIOS_SQRT_CTRL_IRQ_EN
                m_ie = d[1];
`endif
                if (d[0] && !m_busy) begin
                    m_busy    = 1'b1;
                    m_done    = 1'b0;
                    m_to      = 1'b0;
                    job_op    = m_op;
                    job_delay = rsp_delay;
                    exp_start++;
                end
            end
            2'd2: begin
                if (d[1]) m_done = 1'b0;
                if (d[2]) m_to = 1'b0;
            end
            default: ;
        endcase
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a);
        rd_t e;
        e.a = a;
        case (a)
            2'd0: e.v = m_op;
            2'd1: e.v = {30'b0, m_ie, 1'b0};
            2'd2: e.v = {29'b0, m_to, m_done, m_busy};
            default: e.v = m_res;
        endcase
        rdq.push_back(e);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
    endtask

    task automatic settle();
        repeat (T + 6) tick();
    endtask

    // Apply the outcome of the job in flight: completes iff the core
    // answers within T cycles of the launch cycle, otherwise aborts.
    task automatic model_complete();
        if (!m_busy) return;
        m_busy = 1'b0;
        chk("n_start", n_start, exp_start);
        chk("core_operand", start_op, job_op);
        if (job_delay >= 1 && job_delay <= T) begin
            m_done = 1'b1;
            m_res  = isqrt(job_op);
        end else begin
            m_to = 1'b1;
            exp_abort++;
            chk("abort_latency", abort_cyc - start_cyc, T);
        end
        chk("n_abort", n_abort, exp_abort);
    endtask

    task automatic chk_irq();
`ifdef NIOS_SQRT_CTRL_IRQ_EN
        @(negedge clk);
        chk("irq", irq, m_ie & (m_done | m_to));
`endif
        tick();
    endtask

    initial begin
        logic [31:0] op;
        int          d;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = '0;
        writedata  = '0;
        m_op = '0; m_res = '0; job_op = '0;
        m_done = 1'b0; m_to = 1'b0; m_busy = 1'b0; m_ie = 1'b0;
        job_delay = -1;

        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_core_start", core_start, 0);
        chk("rst_core_abort", core_abort, 0);
        chk("rst_readdata", readdata, 0);
        tick();
        for (int i = 0; i < 4; i++) rd(2'(i));
        chk_irq();

        // Normal job: 144 -> 12, done five cycles after launch
        rsp_delay = 5;
        wr(2'd0, 32'd144);
        wr(2'd1, 32'd1);
        rd(2'd2);
        settle();
        model_complete();
        rd(2'd2);
        rd(2'd3);
        rd(2'd0);

        // Core never answers: watchdog abort, RESULT kept
        rsp_delay = -1;
        wr(2'd1, 32'd1);
        rd(2'd2);
        settle();
        model_complete();
        rd(2'd2);
        rd(2'd3);
        rsp_val  = 32'd99;
        rsp_cyc  = cyc + 2;
        rsp_pend = 1'b1;
        repeat (4) tick();
        rd(2'd2);
        rd(2'd3);
        chk("late_done_no_start", n_start, exp_start);

        // Writes during a busy job
        rsp_delay = 10;
        wr(2'd1, 32'd1);
        wr(2'd0, 32'd81);
        wr(2'd1, 32'd1);
        @(negedge clk);
        chk("op_hold", core_operand, 32'd144);
        tick();
        rd(2'd2);
        settle();
        model_complete();
        rd(2'd0);
        rd(2'd2);
        rd(2'd3);
        wr(2'd2, 32'd2);
        rd(2'd2);

        // Completion in the watchdog-limit cycle wins over abort
        wr(2'd0, 32'd49);
        rsp_delay = T;
        wr(2'd1, 32'd1);
        settle();
        model_complete();
        rd(2'd2);
        rd(2'd3);

        // DONE set and W1C DONE in the same cycle: set wins
        rsp_delay = 8;
        wr(2'd1, 32'd1);
        repeat (8) tick();
        wr(2'd2, 32'd2);
        settle();
        model_complete();
        rd(2'd2);

        // Timeout then W1C of TIMEOUT
        rsp_delay = -1;
        wr(2'd1, 32'd1);
        settle();
        model_complete();
        rd(2'd2);
        wr(2'd2, 32'd4);
        rd(2'd2);

`ifdef NIOS_SQRT_CTRL_IRQ_EN
        // Interrupt timing with IE set, then W1C, then IE cleared
        wr(2'd1, 32'd2);
        rsp_delay = 5;
        wr(2'd0, 32'd100);
        wr(2'd1, 32'd3);
        repeat (5) tick();
        @(negedge clk);
        @(negedge clk);
        chk("irq_not_yet", irq, 0);
        @(negedge clk);
        chk("irq_rise", irq, 1);
        tick();
        model_complete();
        rd(2'd1);
        wr(2'd2, 32'd2);
        @(negedge clk);
        chk("irq_hold", irq, 1);
        @(negedge clk);
        chk("irq_clear", irq, 0);
        tick();
        wr(2'd1, 32'd1);
        settle();
        model_complete();
        chk_irq();
        rd(2'd1);
`endif

        // Reset asserted mid-WAIT
        rsp_delay = -1;
        wr(2'd1, 32'd3);
        repeat (10) tick();
        rd(2'd2);
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_start", core_start, 0);
        chk("rst_mid_abort", core_abort, 0);
        chk("rst_mid_readdata", readdata, 0);
`ifdef NIOS_SQRT_CTRL_IRQ_EN
        chk("rst_mid_irq", irq, 0);
`endif
        m_op = '0; m_res = '0;
        m_done = 1'b0; m_to = 1'b0; m_busy = 1'b0; m_ie = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
        rd(2'd2);
        rd(2'd0);
        rd(2'd3);
        rd(2'd1);

        // Randomized jobs
        for (int j = 0; j < 20; j++) begin
            op = $urandom;
            wr(2'd0, op);
            rd(2'd0);
            d = $urandom_range(1, T + 8);
            if ($urandom_range(0, 3) == 0) d = -1;
            rsp_delay = d;
            wr(2'd1, {30'b0, 1'($urandom_range(0, 1)), 1'b1});
            rd(2'd2);
            settle();
            model_complete();
            rd(2'd2);
            rd(2'd3);
            rd(2'd1);
            chk_irq();
            if ($urandom_range(0, 1) == 1) begin
                wr(2'd2, 32'($urandom_range(0, 7)));
                rd(2'd2);
            end
        end

        repeat (3) tick();
        chk("rdq_empty", rdq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
